// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 key-search controller.
// Optional statistics ports are enabled with the KEY_SEARCH_STATS_EN macro
// (see rc4_key_search_ctrl.sv).
package rc4_pkg;

  // Sequencer states, one per step of the per-key engine pipeline.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_INIT_GO,
    ST_INIT_WAIT,
    ST_KSA_GO,
    ST_KSA_WAIT,
    ST_PRGA_GO,
    ST_PRGA_WAIT,
    ST_NEXT_KEY,
    ST_FOUND,
    ST_FAIL
  } ks_state_t;

  // Which engine currently owns the single-port S-memory.
  typedef enum logic [1:0] {
    NONE,
    INIT,
    KSA,
    PRGA
  } s_owner_t;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_LO    = 8'h61;
  localparam logic [7:0] CHAR_HI    = 8'h7A;

  // A plaintext byte is acceptable if it is a space or a lowercase letter.
  function automatic logic is_printable(input logic [7:0] b);
    return (b == CHAR_SPACE) || ((b >= CHAR_LO) && (b <= CHAR_HI));
  endfunction

endpackage

// File: rtl/s_mem_arbiter.sv
// Combinational owner mux for the shared S-memory port.
// An unowned port never writes and presents zero address/data.
module s_mem_arbiter
  import rc4_pkg::*;
(
  input  s_owner_t     i_owner,
  input  logic [7:0]   i_init_addr,
  input  logic [7:0]   i_init_data,
  input  logic         i_init_wren,
  input  logic [7:0]   i_ksa_addr,
  input  logic [7:0]   i_ksa_data,
  input  logic         i_ksa_wren,
  input  logic [7:0]   i_prga_addr,
  input  logic [7:0]   i_prga_data,
  input  logic         i_prga_wren,
  output logic [7:0]   o_addr,
  output logic [7:0]   o_data,
  output logic         o_wren
);

  // Route the owning engine's request to the memory port.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    o_addr = 8'h00;
    o_data = 8'h00;
    o_wren = 1'b0;
    unique case (i_owner)
      INIT: begin
        o_addr = i_init_addr;
        o_data = i_init_data;
        o_wren = i_init_wren;
      end
      KSA: begin
        o_addr = i_ksa_addr;
        o_data = i_ksa_data;
        o_wren = i_ksa_wren;
      end
      PRGA: begin
        o_addr = i_prga_addr;
        o_data = i_prga_data;
        o_wren = i_prga_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Top-level sequencer for the RC4 brute-force decrypt datapath.
// Per candidate key: clear engines, run init, KSA, then PRGA while screening
// every decrypted byte; abort the key on the first unprintable byte.
// Define KEY_SEARCH_STATS_EN to add keys_tried / bytes_rejected counters.
module rc4_key_search_ctrl
  import rc4_pkg::*;
#(
  parameter int               KEY_W     = 24,
  parameter logic [KEY_W-1:0] KEY_FIRST = '0,
  parameter logic [KEY_W-1:0] KEY_LAST  = 24'h3FFFFF,
  parameter int               MSG_LEN   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             eng_clear,
  output logic             init_start,
  output logic             ksa_start,
  output logic             prga_start,
  input  logic             init_done,
  input  logic             ksa_done,
  input  logic             prga_done,
  input  logic [7:0]       init_s_addr,
  input  logic [7:0]       init_s_data,
  input  logic             init_s_wren,
  input  logic [7:0]       ksa_s_addr,
  input  logic [7:0]       ksa_s_data,
  input  logic             ksa_s_wren,
  input  logic [7:0]       prga_s_addr,
  input  logic [7:0]       prga_s_data,
  input  logic             prga_s_wren,
  output logic [7:0]       s_addr,
  output logic [7:0]       s_data,
  output logic             s_wren,
  input  logic             byte_ready,
  input  logic [7:0]       decrypt_byte,
  output logic             valid_byte,
  output logic [KEY_W-1:0] secret_key,
  output logic             busy,
  output logic             found,
  output logic             failed
`ifdef KEY_SEARCH_STATS_EN
  ,
  output logic [KEY_W:0]   keys_tried,
  output logic [31:0]      bytes_rejected
`endif
);

  localparam logic [5:0] MSG_LEN_C = 6'(MSG_LEN);

  ks_state_t        r_state, w_state_nxt;
  s_owner_t         r_owner, w_owner_nxt;
  logic [KEY_W-1:0] r_key, w_key_nxt;
  logic [5:0]       r_byte_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_valid_byte, w_valid_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_found, w_found_nxt;
  logic             r_failed, w_failed_nxt;
  logic             w_search_start;
  logic             w_key_done;
  logic             w_reject;

  // Saturating increment of the accepted-byte count.
  assign w_cnt_inc = (r_byte_cnt == MSG_LEN_C) ? r_byte_cnt : r_byte_cnt + 6'd1;

  // Next-state, next-register values and per-cycle events.
  always_comb begin
    w_state_nxt    = r_state;
    w_key_nxt      = r_key;
    w_cnt_nxt      = r_byte_cnt;
    w_valid_nxt    = 1'b0;
    w_busy_nxt     = r_busy;
    w_found_nxt    = r_found;
    w_failed_nxt   = r_failed;
    w_search_start = 1'b0;
    w_key_done     = 1'b0;
    w_reject       = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_FOUND, ST_FAIL: begin
        if (start) begin
          w_state_nxt    = ST_CLEAR;
          w_busy_nxt     = 1'b1;
          w_found_nxt    = 1'b0;
          w_failed_nxt   = 1'b0;
          w_key_nxt      = KEY_FIRST;
          w_search_start = 1'b1;
        end
      end
      ST_CLEAR: begin
        w_cnt_nxt   = 6'd0;
        w_state_nxt = ST_INIT_GO;
      end
      ST_INIT_GO:   w_state_nxt = ST_INIT_WAIT;
      ST_INIT_WAIT: if (init_done) w_state_nxt = ST_KSA_GO;
      ST_KSA_GO:    w_state_nxt = ST_KSA_WAIT;
      ST_KSA_WAIT:  if (ksa_done) w_state_nxt = ST_PRGA_GO;
      ST_PRGA_GO:   w_state_nxt = ST_PRGA_WAIT;
      ST_PRGA_WAIT: begin
        // A ready seen while the ack is high is the PRGA still leaving its
        // store state, so only a fresh ready is screened.
        if (byte_ready && !r_valid_byte) begin
          w_valid_nxt = 1'b1;
          if (is_printable(decrypt_byte)) begin
            w_cnt_nxt = w_cnt_inc;
            if (prga_done) begin
              w_state_nxt = (w_cnt_inc == MSG_LEN_C) ? ST_FOUND : ST_NEXT_KEY;
            end
          end else begin
            w_reject    = 1'b1;
            w_state_nxt = ST_NEXT_KEY;
          end
        end else if (prga_done) begin
          w_state_nxt = (r_byte_cnt == MSG_LEN_C) ? ST_FOUND : ST_NEXT_KEY;
        end
        if (w_state_nxt == ST_FOUND) begin
          w_found_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_key_done  = 1'b1;
        end
      end
      ST_NEXT_KEY: begin
        w_key_done = 1'b1;
        if (r_key == KEY_LAST) begin
          w_state_nxt  = ST_FAIL;
          w_failed_nxt = 1'b1;
          w_busy_nxt   = 1'b0;
        end else begin
          w_key_nxt   = r_key + KEY_W'(1);
          w_state_nxt = ST_CLEAR;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Memory ownership follows the state being entered, so it only ever
  // changes together with a state transition.
  always_comb begin
    unique case (w_state_nxt)
      ST_INIT_GO, ST_INIT_WAIT: w_owner_nxt = INIT;
      ST_KSA_GO,  ST_KSA_WAIT:  w_owner_nxt = KSA;
      ST_PRGA_GO, ST_PRGA_WAIT: w_owner_nxt = PRGA;
      default:                  w_owner_nxt = NONE;
    endcase
  end

  // Sequencer state and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= NONE;
      r_key        <= KEY_FIRST;
      r_byte_cnt   <= 6'd0;
      r_valid_byte <= 1'b0;
      r_busy       <= 1'b0;
      r_found      <= 1'b0;
      r_failed     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_key        <= w_key_nxt;
      r_byte_cnt   <= w_cnt_nxt;
      r_valid_byte <= w_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_found      <= w_found_nxt;
      r_failed     <= w_failed_nxt;
    end
  end

`ifdef KEY_SEARCH_STATS_EN
  logic [KEY_W:0] r_keys_tried;
  logic [31:0]    r_bytes_rejected;

  // Search statistics: keys attempted this search, bytes rejected overall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_keys_tried     <= '0;
      r_bytes_rejected <= '0;
    end else begin
      if (w_search_start) begin
        r_keys_tried <= '0;
      end else if (w_key_done) begin
        r_keys_tried <= r_keys_tried + (KEY_W+1)'(1);
      end
      if (w_reject) begin
        r_bytes_rejected <= r_bytes_rejected + 32'd1;
      end
    end
  end

  assign keys_tried     = r_keys_tried;
  assign bytes_rejected = r_bytes_rejected;
`endif

  // Engine control pulses are one-cycle states, so they decode directly.
  assign eng_clear  = (r_state == ST_CLEAR);
  assign init_start = (r_state == ST_INIT_GO);
  assign ksa_start  = (r_state == ST_KSA_GO);
  assign prga_start = (r_state == ST_PRGA_GO);
  assign valid_byte = r_valid_byte;
  assign secret_key = r_key;
  assign busy       = r_busy;
  assign found      = r_found;
  assign failed     = r_failed;

  s_mem_arbiter u_arb (
    .i_owner     (r_owner),
    .i_init_addr (init_s_addr),
    .i_init_data (init_s_data),
    .i_init_wren (init_s_wren),
    .i_ksa_addr  (ksa_s_addr),
    .i_ksa_data  (ksa_s_data),
    .i_ksa_wren  (ksa_s_wren),
    .i_prga_addr (prga_s_addr),
    .i_prga_data (prga_s_data),
    .i_prga_wren (prga_s_wren),
    .o_addr      (s_addr),
    .o_data      (s_data),
    .o_wren      (s_wren)
  );

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Self-checking bench for rc4_key_search_ctrl with behavioural engine models.
// Each candidate key gets a byte stream; a reference search over the stream
// table predicts the final key, outcome, clear pulses and byte acks.
module tb_rc4_key_search_ctrl;

  localparam int               KW     = 24;
  localparam logic [KW-1:0]    K_LAST = 24'd7;
  localparam int               NKEYS  = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          eng_clear, init_start, ksa_start, prga_start;
  logic          init_done = 1'b0, ksa_done = 1'b0, prga_done = 1'b0;
  logic [7:0]    init_s_addr = 8'h11, init_s_data = 8'hA1;
  logic          init_s_wren = 1'b1;
  logic [7:0]    ksa_s_addr = 8'h22, ksa_s_data = 8'hB2;
  logic          ksa_s_wren = 1'b1;
  logic [7:0]    prga_s_addr = 8'h33, prga_s_data = 8'hC3;
  logic          prga_s_wren = 1'b1;
  logic [7:0]    s_addr, s_data;
  logic          s_wren;
  logic          byte_ready = 1'b0;
  logic [7:0]    decrypt_byte = 8'h00;
  logic          valid_byte;
  logic [KW-1:0] secret_key;
  logic          busy, found, failed;
`ifdef KEY_SEARCH_STATS_EN
  logic [KW:0]   keys_tried;
  logic [31:0]   bytes_rejected;
`endif

  rc4_key_search_ctrl #(
    .KEY_W(KW), .KEY_FIRST(24'd0), .KEY_LAST(K_LAST), .MSG_LEN(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .eng_clear(eng_clear), .init_start(init_start), .ksa_start(ksa_start),
    .prga_start(prga_start), .init_done(init_done), .ksa_done(ksa_done),
    .prga_done(prga_done),
    .init_s_addr(init_s_addr), .init_s_data(init_s_data), .init_s_wren(init_s_wren),
    .ksa_s_addr(ksa_s_addr), .ksa_s_data(ksa_s_data), .ksa_s_wren(ksa_s_wren),
    .prga_s_addr(prga_s_addr), .prga_s_data(prga_s_data), .prga_s_wren(prga_s_wren),
    .s_addr(s_addr), .s_data(s_data), .s_wren(s_wren),
    .byte_ready(byte_ready), .decrypt_byte(decrypt_byte), .valid_byte(valid_byte),
    .secret_key(secret_key), .busy(busy), .found(found), .failed(failed)
`ifdef KEY_SEARCH_STATS_EN
    , .keys_tried(keys_tried), .bytes_rejected(bytes_rejected)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-key stimulus table: kind 0 = bad byte at bad_pos, 1 = 32 good bytes,
  // 2 = 31 good bytes then prga_done (short message).
  logic [7:0] stream [NKEYS][32];
  int         kind    [NKEYS];
  int         bad_pos [NKEYS];

  int n_clear = 0;
  int n_ack   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit printable(input logic [7:0] b);
    return (b == 8'd32) || (b >= 8'd97 && b <= 8'd122);
  endfunction

  function automatic logic [7:0] rand_good();
    int v = int'($urandom_range(0, 26));
    return (v == 26) ? 8'h20 : 8'(8'h61 + v);
  endfunction

  function automatic logic [7:0] rand_bad();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255)); while (printable(b));
    return b;
  endfunction

  task automatic set_key(input int k, input int knd, input int pos);
    kind[k]    = knd;
    bad_pos[k] = pos;
    for (int i = 0; i < 32; i++) stream[k][i] = rand_good();
    if (knd == 0) stream[k][pos] = rand_bad();
  endtask

  // Engine models: registered-style responses applied just after negedge.
  initial begin
    int       init_cnt = 0;
    int       ksa_cnt  = 0;
    int       gap      = 0;
    int       idx      = 0;
    int       n_bytes  = 0;
    bit       prga_on  = 1'b0;
    logic [2:0] pkey   = 3'd0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n || eng_clear) begin
        init_done = 1'b0; ksa_done = 1'b0; prga_done = 1'b0;
        init_cnt = 0; ksa_cnt = 0; prga_on = 1'b0; byte_ready = 1'b0;
      end else begin
        if (init_start) init_cnt = int'($urandom_range(1, 4));
        else if (init_cnt > 0) begin
          init_cnt--;
          if (init_cnt == 0) init_done = 1'b1;
        end
        if (ksa_start) ksa_cnt = int'($urandom_range(2, 5));
        else if (ksa_cnt > 0) begin
          ksa_cnt--;
          if (ksa_cnt == 0) ksa_done = 1'b1;
        end
        if (prga_start) begin
          prga_on = 1'b1;
          idx     = 0;
          gap     = int'($urandom_range(0, 2));
          pkey    = secret_key[2:0];
          n_bytes = (kind[pkey] == 2) ? 31 : 32;
        end else if (prga_on) begin
          if (byte_ready) begin
            if (valid_byte) begin
              byte_ready = 1'b0;
              idx++;
              gap = int'($urandom_range(0, 2));
              if (idx == n_bytes) begin
                prga_done = 1'b1;
                prga_on   = 1'b0;
              end
            end
          end else if (gap > 0) gap--;
          else begin
            byte_ready   = 1'b1;
            decrypt_byte = stream[pkey][idx];
          end
        end
      end
    end
  end

  // Monitor: memory ownership at phase boundaries and ack pulse shape.
  initial begin
    logic       p_rdy = 1'b0, p_vb = 1'b0;
    logic [7:0] p_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (init_start) check("own_init", 32'({s_wren, s_addr, s_data}), 32'h111A1);
        if (ksa_start)  check("own_ksa",  32'({s_wren, s_addr, s_data}), 32'h122B2);
        if (prga_start) check("own_prga", 32'({s_wren, s_addr, s_data}), 32'h133C3);
        if (eng_clear) begin
          n_clear++;
          check("own_clear", 32'({s_wren, s_addr, s_data}), 32'h0);
        end
        if (p_rdy && !p_vb && !printable(p_byte))
          check("own_nextkey_wren", 32'(s_wren), 32'd0);
        if (valid_byte) begin
          n_ack++;
          check("vb_one_cycle", 32'(p_vb), 32'd0);
        end
      end
      p_rdy  = byte_ready && reset_n;
      p_vb   = valid_byte;
      p_byte = decrypt_byte;
    end
  end

  task automatic run_search(input string tag, input bit double_start);
    bit exp_found = 1'b0;
    int exp_key   = int'(K_LAST);
    int exp_clr   = 0;
    int exp_ack   = 0;
    int cyc       = 0;
    for (int k = 0; k < NKEYS; k++) begin
      exp_clr++;
      if (kind[k] == 0) exp_ack += bad_pos[k] + 1;
      else if (kind[k] == 2) exp_ack += 31;
      else begin
        exp_ack  += 32;
        exp_found = 1'b1;
        exp_key   = k;
        break;
      end
    end
    @(negedge clk);
    n_clear = 0;
    n_ack   = 0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    if (double_start) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    while (!(found || failed) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, 32'(found || failed), 32'd1);
    check({tag, "_found"},  32'(found),  32'(exp_found));
    check({tag, "_failed"}, 32'(failed), 32'(!exp_found));
    check({tag, "_idle"},   32'(busy),   32'd0);
    check({tag, "_key"},    32'(secret_key), 32'(exp_key));
    check({tag, "_clears"}, 32'(n_clear), 32'(exp_clr));
    check({tag, "_acks"},   32'(n_ack),   32'(exp_ack));
`ifdef KEY_SEARCH_STATS_EN
    check({tag, "_keys_tried"}, 32'(keys_tried), 32'(exp_clr));
`endif
  endtask

  initial begin
    int cyc;
    for (int k = 0; k < NKEYS; k++) set_key(k, 0, 0);

    // Reset state.
    #1;
    check("rst_key",   32'(secret_key), 32'd0);
    check("rst_flags", 32'({busy, found, failed}), 32'd0);
    check("rst_pulses", 32'({eng_clear, init_start, ksa_start, prga_start, valid_byte}), 32'd0);
    check("rst_smem",  32'({s_wren, s_addr, s_data}), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Directed: keys 0..2 abort at first byte 0x41, key 3 is all 0x61.
    for (int k = 0; k < NKEYS; k++) begin
      set_key(k, (k == 3) ? 1 : 0, 0);
      for (int i = 0; i < 32; i++) stream[k][i] = 8'h61;
      if (k < 3) stream[k][0] = 8'h41;
    end
    run_search("dir_key3", 1'b0);

    // Randomized searches; the second one also pulses start while busy.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NKEYS; k++)
        set_key(k, ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(0, 1)) * 2,
                int'($urandom_range(0, 31)));
      run_search($sformatf("rand%0d", r), r == 1);
    end

    // Exhaust the range: no key valid, last key short by one byte.
    for (int k = 0; k < NKEYS; k++)
      set_key(k, (k == 7) ? 2 : 0, (k == 0) ? 31 : int'($urandom_range(0, 31)));
    run_search("exhaust", 1'b0);

    // Reset while key 5 is in its KSA phase.
    for (int k = 0; k < NKEYS; k++) set_key(k, 0, int'($urandom_range(0, 3)));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(ksa_start && secret_key == 24'd5) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_reach_key5", 32'(ksa_start && secret_key == 24'd5), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_key",  32'(secret_key), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_wren", 32'(s_wren), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_hold", 32'({busy, s_wren, eng_clear, valid_byte}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // A fresh search after the mid-search reset.
    for (int k = 0; k < NKEYS; k++)
      set_key(k, (k == 6) ? 1 : 0, int'($urandom_range(0, 31)));
    run_search("post_rst", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
